// File: rtl/mux2x32_reg.sv
// 2:1 word selector with a combinational output, a registered copy, and a saturating select-toggle counter.
// Optional even parity of the registered word is built only when MUX2X32_PARITY_EN is defined.
module mux2x32_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             vld_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] sel_cnt,
  output logic             par_q
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] y_d;
  logic             vld_d;
  logic             sel_d;
  logic [CNT_W-1:0] sel_cnt_d;
  logic [CNT_W-1:0] sel_cnt_q;

  assign sel_cnt = sel_cnt_q;

  always_comb begin
    y = s ? a1 : a0;
    // NOTE: every next-state signal starts at its hold value so no path leaves it unassigned (no latch).
    y_d       = y_q;
    vld_d     = vld_q;
    sel_d     = sel_q;
    sel_cnt_d = sel_cnt_q;
    if (en) begin
      y_d   = y;
      sel_d = s;
      vld_d = 1'b1;
      // The first capture after reset has no valid previous select to compare against.
      if (vld_q && (s != sel_q) && (sel_cnt_q != CNT_MAX)) begin
        sel_cnt_d = sel_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      y_q       <= '0;
      vld_q     <= 1'b0;
      sel_q     <= 1'b0;
      sel_cnt_q <= '0;
    end else begin
      y_q       <= y_d;
      vld_q     <= vld_d;
      sel_q     <= sel_d;
      sel_cnt_q <= sel_cnt_d;
    end
  end

`ifdef MUX2X32_PARITY_EN
  logic par_d;

  always_comb begin
    par_d = par_q;
    if (en) begin
      par_d = ^y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`else
  assign par_q = 1'b0;
`endif

endmodule

// File: tb/tb_mux2x32_reg.sv
// Self-checking bench for mux2x32_reg: hand-derived vector table, directed corner sequences,
// and randomized traffic against a behavioural model (default and CNT_W=2 instances).
module tb_mux2x32_reg;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst, en, s;
  logic [WIDTH-1:0] a0, a1;

  logic [WIDTH-1:0] y, y_q, y2, y2_q;
  logic             vld_q, sel_q, par_q, vld2_q, sel2_q, par2_q;
  logic [7:0]       sel_cnt;
  logic [1:0]       sel_cnt2;

  always #5 clk = ~clk;

  mux2x32_reg #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .a0(a0), .a1(a1), .s(s),
    .y(y), .y_q(y_q), .vld_q(vld_q), .sel_q(sel_q), .sel_cnt(sel_cnt), .par_q(par_q)
  );

  mux2x32_reg #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .a0(a0), .a1(a1), .s(s),
    .y(y2), .y_q(y2_q), .vld_q(vld2_q), .sel_q(sel2_q), .sel_cnt(sel_cnt2), .par_q(par2_q)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [WIDTH-1:0] m_yq;
  logic             m_vld, m_sel, m_par;
  int               m_cnt, m_cnt2;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_par(input logic [WIDTH-1:0] w);
`ifdef MUX2X32_PARITY_EN
    int ones = 0;
    for (int i = 0; i < WIDTH; i++) ones += int'(w[i]);
    return (ones % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of inputs, check the comb path, clock once, then check registered outputs.
  task automatic step(input logic r, input logic e, input logic sel,
                      input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    logic [WIDTH-1:0] word;
    rst = r; en = e; s = sel; a0 = d0; a1 = d1;
    #1;
    word = sel ? d1 : d0;
    check("y", y, word);
    check("y2", y2, word);
    if (r) begin
      m_yq = '0; m_vld = 1'b0; m_sel = 1'b0; m_cnt = 0; m_cnt2 = 0; m_par = 1'b0;
    end else if (e) begin
      if (m_vld && (sel != m_sel)) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_yq = word; m_sel = sel; m_vld = 1'b1; m_par = model_par(word);
    end
    @(posedge clk);
    #1;
    check("y_q", y_q, m_yq);
    check("vld_q", {31'b0, vld_q}, {31'b0, m_vld});
    check("sel_q", {31'b0, sel_q}, {31'b0, m_sel});
    check("sel_cnt", {24'b0, sel_cnt}, 32'(m_cnt));
    check("par_q", {31'b0, par_q}, {31'b0, m_par});
    check("y2_q", y2_q, m_yq);
    check("vld2_q", {31'b0, vld2_q}, {31'b0, m_vld});
    check("sel2_q", {31'b0, sel2_q}, {31'b0, m_sel});
    check("sel_cnt2", {30'b0, sel_cnt2}, 32'(m_cnt2));
    check("par2_q", {31'b0, par2_q}, {31'b0, m_par});
  endtask

  typedef struct {
    logic             rst, en, s;
    logic [WIDTH-1:0] a0, a1;
    logic [WIDTH-1:0] exp_y, exp_yq;
    logic             exp_vld;
    int               exp_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst = 1'b1; en = 1'b0; s = 1'b0; a0 = '0; a1 = '0;
    m_yq = '0; m_vld = 1'b0; m_sel = 1'b0; m_cnt = 0; m_cnt2 = 0; m_par = 1'b0;

    // Hand-derived expectations: reset with en high, reset with en low, capture, hold, comb select.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,        32'hFFFF_FFFF, 32'h0,        1'b0, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,        32'hFFFF_FFFF, 32'h0,        1'b0, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,        32'hFFFF_FFFF, 32'h0,        1'b0, 0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0,        32'h1234_5678, 32'h1234_5678, 1'b1, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        32'h0,         32'h1234_5678, 1'b1, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h5,         32'h2,        32'h5,         32'h1234_5678, 1'b1, 0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h5,         32'h2,        32'h2,         32'h1234_5678, 1'b1, 0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h5,         32'h2,        32'h2,         32'h2,         1'b1, 1};

    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].s, vecs[i].a0, vecs[i].a1);
      check($sformatf("tbl%0d_y", i), y, vecs[i].exp_y);
      check($sformatf("tbl%0d_yq", i), y_q, vecs[i].exp_yq);
      check($sformatf("tbl%0d_vld", i), {31'b0, vld_q}, {31'b0, vecs[i].exp_vld});
      check($sformatf("tbl%0d_cnt", i), {24'b0, sel_cnt}, 32'(vecs[i].exp_cnt));
    end

    // Ramp: a0 +1 every cycle, a1 +1 every 2 cycles, s toggles every 5 cycles.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'((i / 5) % 2), 32'(100 + i), 32'(200 + i / 2));
    end
    check("ramp_yq", y_q, 32'(200 + 9 / 2));
    check("ramp_cnt", {24'b0, sel_cnt}, 32'd1);

    // Saturation: first capture, then 6 toggling captures; CNT_W=2 stops at 3.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 32'hA, 32'hB);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b1, 1'(i % 2), 32'hA, 32'hB);
    end
    check("sat_cnt2", {30'b0, sel_cnt2}, 32'd3);
    check("sat_cnt8", {24'b0, sel_cnt}, 32'd6);
    step(1'b0, 1'b0, 1'b1, 32'hA, 32'hB);
    check("sat_hold_cnt", {24'b0, sel_cnt}, 32'd6);
    step(1'b1, 1'b1, 1'b0, 32'hA, 32'hB);
    check("sat_rst_cnt", {24'b0, sel_cnt}, 32'd0);

    // Parity captures.
    step(1'b0, 1'b1, 1'b0, 32'h7, 32'h0);
`ifdef MUX2X32_PARITY_EN
    check("par_7", {31'b0, par_q}, 32'd1);
`else
    check("par_7", {31'b0, par_q}, 32'd0);
`endif
    step(1'b0, 1'b1, 1'b1, 32'h0, 32'h3);
    check("par_3", {31'b0, par_q}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] r0;
      r0 = $urandom;
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           r0, ($urandom_range(0, 7) == 0) ? r0 : WIDTH'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
